// File: rtl/serial_mag_comp.sv
// Serial magnitude comparator: walks operands MSB-first, two bits per cycle,
// through one 2-bit comparator slice with registered EQ/GT cascade.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             eq_c;
  logic             gt_c;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       da;
  logic [1:0]       db;
  logic             eq1;
  logic             gt1;
  logic             last;

  assign a_sh = a_r >> {idx, 1'b0};
  assign b_sh = b_r >> {idx, 1'b0};
  assign da   = a_sh[1:0];
  assign db   = b_sh[1:0];

  // 2-bit comparator slice with cascade inputs
  assign eq1  = eq_c & (da == db);
  assign gt1  = gt_c | (eq_c & (da > db));
  assign last = ~eq1 | (idx == '0);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      eq_c  <= 1'b0;
      gt_c  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            idx  <= IDX_MSB;
            eq_c <= 1'b1;
            gt_c <= 1'b0;
          end
        end
        RUN: begin
          eq_c <= eq1;
          gt_c <= gt1;
          if (last) begin
            eq <= eq1;
            gt <= gt1;
            lt <= ~eq1 & ~gt1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp: WIDTH=8 directed/random cases
// and a WIDTH=2 exhaustive sweep.
module tb_serial_mag_comp;

  typedef struct {
    logic [2:0] res;
    int         n;
    int         e0;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, eq8, gt8, lt8;
  logic       busy2, done2, eq2, gt2, lt2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   bcnt8 = 0;
  int   bcnt2 = 0;
  exp_t q8[$];
  exp_t q2[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  serial_mag_comp #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .eq(eq8), .gt(gt8), .lt(lt8)
  );

  serial_mag_comp #(.WIDTH(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .a(a2), .b(b2), .busy(busy2), .done(done2),
    .eq(eq2), .gt(gt2), .lt(lt2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [7:0] x,
                                 input logic [7:0] y, input int e0);
    exp_t e;
    bit   hit;
    hit  = 0;
    e.n  = w / 2;
    e.e0 = e0;
    for (int k = w / 2 - 1; k >= 0; k--) begin
      if (!hit && (((x >> (2 * k)) & 8'h3) != ((y >> (2 * k)) & 8'h3))) begin
        hit = 1;
        e.n = w / 2 - k;
      end
    end
    if (x == y)     e.res = 3'b100;
    else if (x > y) e.res = 3'b010;
    else            e.res = 3'b001;
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n !== 1'b1) begin
      bcnt8 = 0;
      bcnt2 = 0;
    end else begin
      if (busy8) bcnt8++;
      if (busy2) bcnt2++;
      if (busy8 | done8) chk("busy_done_excl8", busy8 & done8, 0);
      if (done8 === 1'b1) begin
        if (q8.size() == 0) chk("spurious_done8", 1, 0);
        else begin
          exp_t it;
          it = q8.pop_front();
          chk("res8", {eq8, gt8, lt8}, it.res);
          chk("lat8", cyc - it.e0, it.n);
          chk("busy_cyc8", bcnt8, it.n);
        end
        bcnt8 = 0;
      end
      if (done2 === 1'b1) begin
        if (q2.size() == 0) chk("spurious_done2", 1, 0);
        else begin
          exp_t it;
          it = q2.pop_front();
          chk("res2", {eq2, gt2, lt2}, it.res);
          chk("lat2", cyc - it.e0, it.n);
          chk("busy_cyc2", bcnt2, it.n);
        end
        bcnt2 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int sel);
    int k;
    k = 0;
    while (((sel == 8) ? q8.size() : q2.size()) != 0 && k < 60) begin
      tick();
      k++;
    end
    chk("drain_timeout", (sel == 8) ? q8.size() : q2.size(), 0);
  endtask

  task automatic cmp8(input logic [7:0] x, input logic [7:0] y);
    a8     = x;
    b8     = y;
    start8 = 1'b1;
    q8.push_back(model(8, x, y, cyc + 1));
    tick();
    start8 = 1'b0;
    a8     = ~x;
    b8     = ~y;
    drain(8);
  endtask

  task automatic cmp2(input logic [1:0] x, input logic [1:0] y);
    a2     = x;
    b2     = y;
    start2 = 1'b1;
    q2.push_back(model(2, {6'd0, x}, {6'd0, y}, cyc + 1));
    tick();
    start2 = 1'b0;
    drain(2);
  endtask

  initial begin
    reset_n = 1'b0;
    start8  = 1'b1;
    start2  = 1'b1;
    a8      = 8'h5A;
    b8      = 8'h3C;
    a2      = 2'd0;
    b2      = 2'd0;
    tick();
    tick();
    chk("rst_outs", {busy8, done8, eq8, gt8, lt8}, 0);
    reset_n = 1'b1;
    start8  = 1'b0;
    start2  = 1'b0;
    tick();
    tick();
    chk("rst_no_capture", {busy8, done8, busy2, done2}, 0);

    cmp8(8'hA5, 8'hA5);
    cmp8(8'hC0, 8'h40);
    cmp8(8'h12, 8'h13);

    // start held high while busy must be ignored until IDLE
    a8     = 8'h12;
    b8     = 8'h13;
    start8 = 1'b1;
    q8.push_back(model(8, 8'h12, 8'h13, cyc + 1));
    tick();
    a8 = 8'hFF;
    b8 = 8'h00;
    repeat (3) tick();
    drain(8);
    q8.push_back(model(8, 8'hFF, 8'h00, cyc + 1));
    tick();
    start8 = 1'b0;
    drain(8);
    chk("held_gt", {eq8, gt8, lt8}, 3'b010);

    // abort mid-RUN
    a8     = 8'hA5;
    b8     = 8'hA5;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    chk("midrun_busy", busy8, 1);
    reset_n = 1'b0;
    tick();
    chk("abort_outs", {busy8, done8, eq8, gt8, lt8}, 0);
    reset_n = 1'b1;
    repeat (6) tick();
    chk("abort_quiet", {busy8, done8, eq8, gt8, lt8}, 0);
    cmp8(8'h01, 8'h02);

    repeat (6) cmp8(8'($urandom), 8'($urandom));

    for (int i = 0; i < 16; i++) cmp2(2'(i >> 2), 2'(i));

    repeat (3) tick();
    chk("q_empty", q8.size() + q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
